// File: rtl/demux_rr_sched_pkg.sv
// Shared types for the 1-to-4 demux scheduler: lane count, lane index type,
// the IDLE/SEND state encoding and a one-hot helper.
package demux_sched_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // One-hot lane valid vector for a lane index.
  function automatic logic [3:0] lane_onehot(input lane_idx_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/demux_rr_sched_pick.sv
// Combinational round-robin picker: returns the first enabled lane when
// scanning ptr+1, ptr+2, ptr+3, ptr (mod 4). o_any_en flags that at least
// one lane is enabled; o_pick is meaningless when it is low.
module demux_rr_pick
  import demux_sched_pkg::*;
(
  input  lane_idx_t  i_ptr,
  input  logic [3:0] i_lane_en,
  output lane_idx_t  o_pick,
  output logic       o_any_en
);

  // Scan the four lanes starting just after the pointer; first hit wins.
  always_comb begin : p_scan
    lane_idx_t v_idx;
    logic      v_found;
    o_pick   = i_ptr;
    o_any_en = |i_lane_en;
    v_found  = 1'b0;
    v_idx    = i_ptr;
    for (int k = 1; k <= LANES; k++) begin
      v_idx = i_ptr + lane_idx_t'(k);
      if (!v_found && i_lane_en[v_idx]) begin
        o_pick  = v_idx;
        v_found = 1'b1;
      end else begin
        v_found = v_found;
      end
    end
  end

endmodule

// File: rtl/demux_rr_sched.sv
// Scheduler/sequencer for the 1-to-4 demux datapath. Holds one word in a
// single-entry register and presents it to one lane, chosen explicitly or
// by round-robin over the enabled lanes.
// Optional feature macro: DEMUX_SCHED_STATS_EN adds per-lane saturating
// grant counters (cnt_clr / grant_cnt ports).
module demux_rr_sched
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dest_vld,
  input  logic [1:0]        in_dest,
  input  logic [3:0]        lane_en,
  output logic [1:0]        sel,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
`ifdef DEMUX_SCHED_STATS_EN
  input  logic              cnt_clr,
  output logic [4*CNT_W-1:0] grant_cnt,
`endif
  output logic              drop_err
);

  state_t            r_state;
  lane_idx_t         r_ptr;
  lane_idx_t         r_sel;
  logic [3:0]        r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_drop_err;

  lane_idx_t w_ptr_eff;
  lane_idx_t w_pick;
  logic      w_any_en;
  lane_idx_t w_next_sel;
  logic      w_out_hs;
  logic      w_accept;
  logic      w_drop;
  logic      w_dest_ok;

  // Output handshake on the held word; ready on other lanes is ignored.
  assign w_out_hs  = (r_state == SEND) && out_ready[r_sel];
  assign w_dest_ok = in_dest_vld || w_any_en;
  assign in_ready  = ((r_state == IDLE) || w_out_hs) && w_dest_ok;
  assign w_accept  = in_valid && in_ready;
  assign w_drop    = in_dest_vld && !lane_en[in_dest];

  // A grant completing this cycle already moves the pointer, so a word
  // reloaded in the same cycle must scan from the lane just released;
  // otherwise back-to-back round-robin words would repeat a lane.
  assign w_ptr_eff = w_out_hs ? r_sel : r_ptr;

  demux_rr_pick u_pick (
    .i_ptr     (w_ptr_eff),
    .i_lane_en (lane_en),
    .o_pick    (w_pick),
    .o_any_en  (w_any_en)
  );

  // Destination of the word being accepted.
  always_comb begin
    if (in_dest_vld) begin
      w_next_sel = in_dest;
    end else begin
      w_next_sel = w_pick;
    end
  end

  // Holding register, state, pointer and drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= 2'd3;
      r_sel       <= 2'd0;
      r_out_valid <= 4'b0000;
      r_out_data  <= {DATA_W{1'b0}};
      r_drop_err  <= 1'b0;
    end else begin
      r_drop_err <= 1'b0;
      if (w_out_hs) begin
        r_ptr <= r_sel;
      end
      if (w_accept) begin
        r_out_data <= in_data;
        r_sel      <= w_next_sel;
        if (w_drop) begin
          r_state     <= IDLE;
          r_out_valid <= 4'b0000;
          r_drop_err  <= 1'b1;
        end else begin
          r_state     <= SEND;
          r_out_valid <= lane_onehot(w_next_sel);
        end
      end else if (w_out_hs) begin
        r_state     <= IDLE;
        r_out_valid <= 4'b0000;
      end
    end
  end

  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign drop_err  = r_drop_err;

`ifdef DEMUX_SCHED_STATS_EN
  logic [CNT_W-1:0] r_cnt [LANES];

  // Per-lane saturating grant counters; clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        r_cnt[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (cnt_clr) begin
          r_cnt[i] <= {CNT_W{1'b0}};
        end else if (w_out_hs && (r_sel == lane_idx_t'(i)) &&
                     (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end
`endif

endmodule

// File: tb/tb_demux_rr_sched.sv
// Scoreboard bench for demux_rr_sched: the driver pushes the hand-computed
// lane/data of every accepted word; a monitor pops and compares on each
// output handshake. Directed checks cover reset, stalls, drops and reset
// during SEND. Build with DEMUX_SCHED_STATS_EN to also cover the counters.
module tb_demux_rr_sched;

`ifdef DEMUX_SCHED_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  typedef struct packed {
    logic [3:0] lane;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_dest_vld = 1'b0;
  logic [1:0] in_dest = 2'd0;
  logic [3:0] lane_en = 4'hF;
  logic [1:0] sel;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [3:0] out_ready = 4'hF;
  logic       drop_err;
`ifdef DEMUX_SCHED_STATS_EN
  logic       cnt_clr = 1'b0;
  logic [4*CNT_W-1:0] grant_cnt;
`endif

  exp_t exp_q[$];
  int   exp_drop_n = 0;
  int   n_total = 0;
  int   n_pass  = 0;
  int   waits;

  always #5 clk = ~clk;

  demux_rr_sched #(.DATA_W(8), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_dest_vld (in_dest_vld),
    .in_dest     (in_dest),
    .lane_en     (lane_en),
    .sel         (sel),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
`ifdef DEMUX_SCHED_STATS_EN
    .cnt_clr     (cnt_clr),
    .grant_cnt   (grant_cnt),
`endif
    .drop_err    (drop_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask

  // Offer one word; push its expectation once acceptance is certain.
  // Leaves in_valid high so consecutive calls stream back-to-back.
  task automatic send(input logic [7:0] d, input logic dv, input logic [1:0] dst,
                      input logic [3:0] exp_lane, input logic is_drop, output int nwait);
    exp_t e;
    in_valid = 1'b1; in_data = d; in_dest_vld = dv; in_dest = dst;
    nwait = 0;
    @(negedge clk);
    while (!in_ready && nwait < 50) begin
      @(negedge clk);
      nwait++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else if (is_drop) begin
      exp_drop_n++;
    end else begin
      e.lane = exp_lane; e.data = d;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_dest_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare each output handshake and drop pulse with the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if ((out_valid & out_ready) != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {28'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_lane", {28'd0, out_valid}, {28'd0, e.lane});
          check("out_data", {24'd0, out_data}, {24'd0, e.data});
        end
      end
      if (drop_err) begin
        check("drop_expected", (exp_drop_n > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_drop_n > 0) exp_drop_n--;
      end
    end
  end

  initial begin
    // Reset values while rst held
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_sel", {30'd0, sel}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_drop_err", {31'd0, drop_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // 1. Four round-robin words, all ready: lanes 0,1,2,3 back-to-back
    lane_en = 4'hF; out_ready = 4'hF;
    send(8'hA1, 1'b0, 2'd0, 4'b0001, 1'b0, waits);
    #1 check("t1_latency", {28'd0, out_valid}, 32'h1);
    send(8'hB2, 1'b0, 2'd0, 4'b0010, 1'b0, waits);
    check("t1_b2b_B", waits, 32'd0);
    send(8'hC3, 1'b0, 2'd0, 4'b0100, 1'b0, waits);
    check("t1_b2b_C", waits, 32'd0);
    send(8'hD4, 1'b0, 2'd0, 4'b1000, 1'b0, waits);
    check("t1_b2b_D", waits, 32'd0);
    idle(2);
    check("t1_drained", {28'd0, out_valid}, 32'd0);

    // 2. Lanes 1 and 3 enabled: 1, 3, 1 (pointer wraps 3 -> 1)
    lane_en = 4'b1010;
    send(8'h11, 1'b0, 2'd0, 4'b0010, 1'b0, waits);
    send(8'h22, 1'b0, 2'd0, 4'b1000, 1'b0, waits);
    send(8'h33, 1'b0, 2'd0, 4'b0010, 1'b0, waits);
    idle(2);

    // 3. Explicit destination to a disabled lane: dropped, ptr stays at 1
    send(8'h44, 1'b1, 2'd0, 4'b0000, 1'b1, waits);
    in_valid = 1'b0; in_dest_vld = 1'b0;
    #1;
    check("t3_drop_pulse", {31'd0, drop_err}, 32'd1);
    check("t3_no_valid", {28'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("t3_drop_one_cycle", {31'd0, drop_err}, 32'd0);
    send(8'h55, 1'b0, 2'd0, 4'b1000, 1'b0, waits);
    idle(2);

    // 4. Held on lane 3 while only lane 0 is ready: stable, stalled
    lane_en = 4'hF; out_ready = 4'b0001;
    send(8'h66, 1'b1, 2'd3, 4'b1000, 1'b0, waits);
    in_valid = 1'b1; in_dest_vld = 1'b0; in_data = 8'h77;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t4_hold_valid", {28'd0, out_valid}, 32'h8);
      check("t4_hold_data", {24'd0, out_data}, 32'h66);
      check("t4_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 4'hF;
    @(posedge clk); #1;
    check("t4_released", {28'd0, out_valid}, 32'd0);

    // 5. No lane enabled in round-robin mode: stall without drop
    lane_en = 4'b0000; in_valid = 1'b1; in_dest_vld = 1'b0; in_data = 8'h88;
    repeat (3) begin
      @(negedge clk);
      check("t5_stall_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    check("t5_no_drop", {31'd0, drop_err}, 32'd0);
    idle(1);
    // Reset while a word is held: discarded immediately
    lane_en = 4'hF; out_ready = 4'b0000;
    send(8'h99, 1'b0, 2'd0, 4'b0001, 1'b0, waits);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_held", {28'd0, out_valid}, 32'h1);
    #2 rst = 1'b1;
    #1 check("t5_rst_valid", {28'd0, out_valid}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    check("t5_rst_data", {24'd0, out_data}, 32'd0);
    out_ready = 4'hF;
    send(8'hAA, 1'b0, 2'd0, 4'b0001, 1'b0, waits);
    idle(2);

`ifdef DEMUX_SCHED_STATS_EN
    // 6. Saturating grant counter on lane 0, then clear
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    for (int w = 0; w < 5; w++) begin
      send(8'hC0 + 8'(w), 1'b1, 2'd0, 4'b0001, 1'b0, waits);
    end
    idle(2);
    check("t6_cnt_sat", {30'd0, grant_cnt[1:0]}, 32'd3);
    check("t6_cnt_lane1", {30'd0, grant_cnt[3:2]}, 32'd0);
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    check("t6_cnt_clr", {30'd0, grant_cnt[1:0]}, 32'd0);
`endif

    idle(3);
    check("sb_empty", exp_q.size(), 32'd0);
    check("drops_seen", exp_drop_n, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

endmodule
